// File: rtl/wb_arb3_ctrl.sv
// wb_arb3_ctrl: three-master Wishbone arbiter with a round-robin grant held for the owner's whole cycle.
// Optional slave-stall watchdog is compiled in when WB_ARB3_WATCHDOG_EN is defined.
module wb_arb3_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [95:0] m_adr_i,
  input  logic [95:0] m_dat_i,
  input  logic [11:0] m_sel_i,
  input  logic [2:0]  m_we_i,
  input  logic [2:0]  m_cyc_i,
  input  logic [2:0]  m_stb_i,
  input  logic [8:0]  m_cti_i,
  input  logic [5:0]  m_bte_i,
  output logic [31:0] m_dat_o,
  output logic [2:0]  m_ack_o,
  output logic [2:0]  m_err_o,
  output logic [2:0]  m_rty_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [2:0]  grant_o,
  output logic        timeout_o,
  output logic        state_o
);

  // Handshake: a beat completes in any cycle where s_cyc_o & s_stb_o are high and the
  // slave answers with s_ack_i, s_err_i or s_rty_i; the arbiter registers no beat data.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_grant;
  logic [2:0]  w_grant_nxt;
  logic [1:0]  r_last;
  logic [1:0]  w_last_nxt;
  logic [2:0]  w_pick;
  logic [1:0]  w_own_idx;
  logic        w_own;
  logic        w_own_cyc;
  logic        w_own_stb;
  logic        w_wd_fire;
  logic [31:0] w_adr;
  logic [31:0] w_dat;
  logic [3:0]  w_sel;
  logic        w_we;
  logic [2:0]  w_cti;
  logic [1:0]  w_bte;

  assign w_own     = (r_state == ST_OWN);
  assign w_own_cyc = |(r_grant & m_cyc_i);
  assign w_own_stb = |(r_grant & m_stb_i);

  always_comb begin
    w_own_idx = 2'd0;
    if (r_grant[1]) begin
      w_own_idx = 2'd1;
    end else if (r_grant[2]) begin
      w_own_idx = 2'd2;
    end
  end

  // Search starts at the master after the last owner and wraps around.
  always_comb begin
    w_pick = 3'b000;
    case (r_last)
      2'd0: begin
        if      (m_cyc_i[1]) w_pick = 3'b010;
        else if (m_cyc_i[2]) w_pick = 3'b100;
        else if (m_cyc_i[0]) w_pick = 3'b001;
      end
      2'd1: begin
        if      (m_cyc_i[2]) w_pick = 3'b100;
        else if (m_cyc_i[0]) w_pick = 3'b001;
        else if (m_cyc_i[1]) w_pick = 3'b010;
      end
      default: begin
        if      (m_cyc_i[0]) w_pick = 3'b001;
        else if (m_cyc_i[1]) w_pick = 3'b010;
        else if (m_cyc_i[2]) w_pick = 3'b100;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = w_pick;
        end
      end
      ST_OWN: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 3'b000;
          w_last_nxt  = w_own_idx;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 3'b000;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_last  <= 2'd2;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_adr = m_adr_i[31:0];
    w_dat = m_dat_i[31:0];
    w_sel = m_sel_i[3:0];
    w_we  = m_we_i[0];
    w_cti = m_cti_i[2:0];
    w_bte = m_bte_i[1:0];
    case (w_own_idx)
      2'd1: begin
        w_adr = m_adr_i[63:32];
        w_dat = m_dat_i[63:32];
        w_sel = m_sel_i[7:4];
        w_we  = m_we_i[1];
        w_cti = m_cti_i[5:3];
        w_bte = m_bte_i[3:2];
      end
      2'd2: begin
        w_adr = m_adr_i[95:64];
        w_dat = m_dat_i[95:64];
        w_sel = m_sel_i[11:8];
        w_we  = m_we_i[2];
        w_cti = m_cti_i[8:6];
        w_bte = m_bte_i[5:4];
      end
      default: begin
      end
    endcase
  end

`ifdef WB_ARB3_WATCHDOG_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  logic [7:0] r_wd_cnt;
  logic       r_timeout;
  logic       w_resp;

  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  // A genuine slave response in the limit cycle wins over the forced error.
  assign w_wd_fire = w_own && w_own_stb && !w_resp && (r_wd_cnt == LP_TIMEOUT);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wd_cnt  <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_own || !w_own_stb || w_resp || w_wd_fire) begin
        r_wd_cnt <= 8'd0;
      end else begin
        r_wd_cnt <= r_wd_cnt + 8'd1;
      end
      if (w_wd_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_wd_fire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  assign s_sel_o = w_sel;
  assign s_we_o  = w_we;
  assign s_cti_o = w_cti;
  assign s_bte_o = w_bte;
  assign s_cyc_o = w_own & w_own_cyc;
  assign s_stb_o = w_own & w_own_stb & ~w_wd_fire;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = w_own ? (r_grant & {3{s_ack_i}}) : 3'b000;
  assign m_err_o = w_own ? (r_grant & {3{s_err_i | w_wd_fire}}) : 3'b000;
  assign m_rty_o = w_own ? (r_grant & {3{s_rty_i}}) : 3'b000;

  assign grant_o = r_grant;
  assign state_o = r_state;

endmodule

// File: tb/tb_wb_arb3_ctrl.sv
// Self-checking bench for wb_arb3_ctrl: directed scenarios plus randomized traffic checked
// against a round-robin ownership model; watchdog scenario follows WB_ARB3_WATCHDOG_EN.
module tb_wb_arb3_ctrl;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [95:0] m_adr_i, m_dat_i;
  logic [11:0] m_sel_i;
  logic [2:0]  m_we_i, m_cyc_i, m_stb_i;
  logic [8:0]  m_cti_i;
  logic [5:0]  m_bte_i;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack_o, m_err_o, m_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [2:0]  grant_o;
  logic        timeout_o;
  logic        state_o;

  int n_checks = 0;
  int n_fail = 0;
  int mdl_owner;
  int mdl_last;
  logic [2:0] exp_q[$];

  wb_arb3_ctrl #(.TIMEOUT(16)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk = ~wb_clk;

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not complete within time limit");
    $fatal(1, "simulation time limit");
  end

  // ---------------- reference model ----------------
  function automatic int rr_next(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mdl_owner <= -1;
      mdl_last  <= 2;
    end else if (mdl_owner < 0) begin
      mdl_owner <= rr_next(m_cyc_i, mdl_last);
    end else if (!m_cyc_i[mdl_owner]) begin
      mdl_last  <= mdl_owner;
      mdl_owner <= -1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  // Leaves reset released just after a falling edge; the next rising edge arbitrates on cyc.
  task automatic do_reset(input logic [2:0] cyc);
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    clear_inputs();
    m_cyc_i = cyc;
    m_stb_i = cyc;
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    clear_inputs();
    m_cyc_i = 3'b111; m_stb_i = 3'b111;
    s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1;
    #2;
    n_checks++;
    if (grant_o !== 3'b000 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: grant=%b cyc=%b stb=%b required 000 0 0", grant_o, s_cyc_o, s_stb_o);
    end
    n_checks++;
    if (m_ack_o !== 3'b000 || m_err_o !== 3'b000 || m_rty_o !== 3'b000 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: ack=%b err=%b rty=%b to=%b required all 0", m_ack_o, m_err_o, m_rty_o, timeout_o);
    end
    @(posedge wb_clk); #1;
    n_checks++;
    if (grant_o !== 3'b000 || state_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: grant=%b state=%b required 000 0", grant_o, state_o);
    end
    @(negedge wb_clk);
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    wb_rst_n = 1'b1;
    @(negedge wb_clk); #2;
    n_checks++;
    if (grant_o !== 3'b001 || s_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_arb: grant=%b cyc=%b required 001 1", grant_o, s_cyc_o);
    end
    m_cyc_i = 3'b000; m_stb_i = 3'b000;
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic test_round_robin();
    logic [2:0] g;
    do_reset(3'b111);
    s_ack_i = 1'b1;
    exp_q = {3'b001, 3'b010, 3'b100, 3'b001};
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      @(negedge wb_clk);
      m_cyc_i = 3'b111; m_stb_i = 3'b111;
      #2;
      n_checks++;
      if (grant_o !== g || m_ack_o !== g || s_cyc_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant: grant=%b ack=%b cyc=%b required %b %b 1", grant_o, m_ack_o, s_cyc_o, g, g);
      end
      @(negedge wb_clk);
      m_cyc_i = 3'b111 & ~g; m_stb_i = 3'b111 & ~g;
      #2;
      n_checks++;
      if (grant_o !== g || s_cyc_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_release: grant=%b cyc=%b required %b 0", grant_o, s_cyc_o, g);
      end
      @(negedge wb_clk);
      m_cyc_i = 3'b111; m_stb_i = 3'b111;
      #2;
      n_checks++;
      if (grant_o !== 3'b000 || s_cyc_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle_gap: grant=%b cyc=%b required 000 0", grant_o, s_cyc_o);
      end
    end
    clear_inputs();
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic test_write();
    do_reset(3'b000);
    @(negedge wb_clk);
    m_adr_i = {32'hAAAA_0000, 32'h0000_0040, 32'h5555_0000};
    m_dat_i = {32'h1111_2222, 32'hDEAD_BEEF, 32'h3333_4444};
    m_sel_i = 12'h3F1;
    m_we_i  = 3'b010; m_cyc_i = 3'b010; m_stb_i = 3'b010;
    s_dat_i = 32'hCAFE_F00D;
    #2;
    n_checks++;
    if (s_cyc_o !== 1'b0 || grant_o !== 3'b000) begin
      n_fail++;
      $display("FAIL write_latency: cyc=%b grant=%b required 0 000", s_cyc_o, grant_o);
    end
    @(negedge wb_clk); #2;
    n_checks++;
    if (grant_o !== 3'b010 || state_o !== 1'b1 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ctl: grant=%b st=%b cyc=%b stb=%b we=%b required 010 1 1 1 1",
               grant_o, state_o, s_cyc_o, s_stb_o, s_we_o);
    end
    n_checks++;
    if (s_adr_o !== 32'h0000_0040 || s_dat_o !== 32'hDEAD_BEEF || s_sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL write_data: adr=%h dat=%h sel=%h required 00000040 deadbeef f", s_adr_o, s_dat_o, s_sel_o);
    end
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (m_ack_o !== 3'b010 || m_err_o !== 3'b000 || m_dat_o !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL write_ack: ack=%b err=%b dat=%h required 010 000 cafef00d", m_ack_o, m_err_o, m_dat_o);
    end
    @(negedge wb_clk);
    clear_inputs();
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic test_burst();
    logic [2:0] cti_tab [5];
    logic       stb_tab [5];
    cti_tab = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
    stb_tab = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset(3'b000);
    @(negedge wb_clk);
    m_cyc_i = 3'b101; m_stb_i = 3'b101;
    m_cti_i = {3'b111, 3'b000, cti_tab[0]};
    m_adr_i = {32'h2000_0000, 32'h0, 32'h0000_0100};
    s_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk);
      m_stb_i[0] = stb_tab[i];
      m_cti_i[2:0] = cti_tab[i];
      m_adr_i[31:0] = 32'h0000_0100 + 32'(4 * i);
      #2;
      n_checks++;
      if (grant_o !== 3'b001 || m_ack_o !== 3'b001 || s_stb_o !== stb_tab[i] ||
          s_cti_o !== cti_tab[i] || s_adr_o !== 32'h0000_0100 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL burst_beat%0d: grant=%b ack=%b stb=%b cti=%b adr=%h required 001 001 %b %b %h",
                 i, grant_o, m_ack_o, s_stb_o, s_cti_o, s_adr_o, stb_tab[i], cti_tab[i],
                 32'h0000_0100 + 32'(4 * i));
      end
    end
    @(negedge wb_clk);
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    #2;
    n_checks++;
    if (grant_o !== 3'b001 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_drop: grant=%b cyc=%b required 001 0", grant_o, s_cyc_o);
    end
    @(negedge wb_clk); #2;
    n_checks++;
    if (grant_o !== 3'b000) begin
      n_fail++;
      $display("FAIL burst_gap: grant=%b required 000", grant_o);
    end
    @(negedge wb_clk); #2;
    n_checks++;
    if (grant_o !== 3'b100 || s_adr_o !== 32'h2000_0000 || s_cti_o !== 3'b111) begin
      n_fail++;
      $display("FAIL burst_next_owner: grant=%b adr=%h cti=%b required 100 20000000 111", grant_o, s_adr_o, s_cti_o);
    end
    clear_inputs();
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic test_reset_mid_burst();
    do_reset(3'b000);
    @(negedge wb_clk);
    m_cyc_i = 3'b100; m_stb_i = 3'b100; m_cti_i = 9'b010_000_000;
    s_ack_i = 1'b1;
    @(negedge wb_clk); #2;
    n_checks++;
    if (grant_o !== 3'b100 || s_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_own: grant=%b cyc=%b required 100 1", grant_o, s_cyc_o);
    end
    @(negedge wb_clk); #2;
    wb_rst_n = 1'b0;
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 3'b000 || m_ack_o !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_async: cyc=%b stb=%b grant=%b ack=%b required 0 0 000 000",
               s_cyc_o, s_stb_o, grant_o, m_ack_o);
    end
    m_cyc_i = 3'b101; m_stb_i = 3'b101;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk); #2;
    n_checks++;
    if (grant_o !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_tie: grant=%b required 001", grant_o);
    end
    clear_inputs();
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic test_random();
    logic [2:0]  eg;
    logic        ecyc, estb;
    logic [75:0] exp_req, act_req;
    do_reset(3'b000);
    for (int c = 0; c < 400; c++) begin
      @(negedge wb_clk);
      for (int m = 0; m < 3; m++) begin
        m_cyc_i[m] = ($urandom_range(0, 9) < 7);
        m_stb_i[m] = $urandom_range(0, 1);
      end
      m_we_i  = 3'($urandom_range(0, 7));
      m_adr_i = {$urandom, $urandom, $urandom};
      m_dat_i = {$urandom, $urandom, $urandom};
      m_sel_i = 12'($urandom);
      m_cti_i = 9'($urandom);
      m_bte_i = 6'($urandom);
      s_dat_i = $urandom;
      s_ack_i = $urandom_range(0, 1);
      s_err_i = ($urandom_range(0, 7) == 0);
      s_rty_i = ($urandom_range(0, 7) == 0);
`ifdef WB_ARB3_WATCHDOG_EN
      if (c % 8 == 0) s_ack_i = 1'b1;
`endif
      #2;
      eg   = (mdl_owner < 0) ? 3'b000 : 3'(1 << mdl_owner);
      ecyc = (mdl_owner >= 0) && m_cyc_i[mdl_owner];
      estb = (mdl_owner >= 0) && m_stb_i[mdl_owner];
      n_checks++;
      if (grant_o !== eg || s_cyc_o !== ecyc || s_stb_o !== estb) begin
        n_fail++;
        $display("FAIL rand_grant c=%0d: grant=%b cyc=%b stb=%b required %b %b %b",
                 c, grant_o, s_cyc_o, s_stb_o, eg, ecyc, estb);
      end
      n_checks++;
      if (m_ack_o !== (eg & {3{s_ack_i}}) || m_err_o !== (eg & {3{s_err_i}}) ||
          m_rty_o !== (eg & {3{s_rty_i}}) || m_dat_o !== s_dat_i) begin
        n_fail++;
        $display("FAIL rand_resp c=%0d: ack=%b err=%b rty=%b dat=%h required %b %b %b %h", c,
                 m_ack_o, m_err_o, m_rty_o, m_dat_o, eg & {3{s_ack_i}}, eg & {3{s_err_i}},
                 eg & {3{s_rty_i}}, s_dat_i);
      end
      if (mdl_owner >= 0) begin
        exp_req = {m_adr_i[32*mdl_owner +: 32], m_dat_i[32*mdl_owner +: 32], m_sel_i[4*mdl_owner +: 4],
                   m_we_i[mdl_owner], m_cti_i[3*mdl_owner +: 3], m_bte_i[2*mdl_owner +: 2]};
        act_req = {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o};
        n_checks++;
        if (act_req !== exp_req) begin
          n_fail++;
          $display("FAIL rand_mux c=%0d: got %h required %h", c, act_req, exp_req);
        end
      end
    end
    clear_inputs();
    repeat (3) @(negedge wb_clk);
  endtask

`ifdef WB_ARB3_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset(3'b000);
    @(negedge wb_clk);
    m_cyc_i = 3'b010; m_stb_i = 3'b010;
    for (int i = 1; i <= 20; i++) begin
      @(negedge wb_clk); #2;
      n_checks++;
      if (i < 17 && (m_err_o !== 3'b000 || s_stb_o !== 1'b1 || timeout_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL wd_pre%0d: err=%b stb=%b to=%b required 000 1 0", i, m_err_o, s_stb_o, timeout_o);
      end else if (i == 17 && (m_err_o !== 3'b010 || s_stb_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL wd_fire: err=%b stb=%b required 010 0", m_err_o, s_stb_o);
      end else if (i > 17 && (m_err_o !== 3'b000 || s_stb_o !== 1'b1 || timeout_o !== 1'b1)) begin
        n_fail++;
        $display("FAIL wd_post%0d: err=%b stb=%b to=%b required 000 1 1", i, m_err_o, s_stb_o, timeout_o);
      end
    end
    do_reset(3'b000);
    @(negedge wb_clk);
    m_cyc_i = 3'b010; m_stb_i = 3'b010;
    for (int i = 1; i <= 18; i++) begin
      @(negedge wb_clk);
      s_ack_i = (i == 17);
      #2;
      if (i == 17) begin
        n_checks++;
        if (m_err_o !== 3'b000 || m_ack_o !== 3'b010 || s_stb_o !== 1'b1) begin
          n_fail++;
          $display("FAIL wd_precedence: err=%b ack=%b stb=%b required 000 010 1", m_err_o, m_ack_o, s_stb_o);
        end
      end
      if (i == 18) begin
        n_checks++;
        if (timeout_o !== 1'b0 || m_err_o !== 3'b000) begin
          n_fail++;
          $display("FAIL wd_no_flag: to=%b err=%b required 0 000", timeout_o, m_err_o);
        end
      end
    end
    clear_inputs();
    repeat (2) @(negedge wb_clk);
  endtask
`else
  task automatic test_watchdog();
    do_reset(3'b000);
    @(negedge wb_clk);
    m_cyc_i = 3'b010; m_stb_i = 3'b010;
    for (int i = 1; i <= 40; i++) begin
      @(negedge wb_clk); #2;
      n_checks++;
      if (m_err_o !== 3'b000 || grant_o !== 3'b010 || s_stb_o !== 1'b1 || timeout_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: err=%b grant=%b stb=%b to=%b required 000 010 1 0",
                 i, m_err_o, grant_o, s_stb_o, timeout_o);
      end
    end
    clear_inputs();
    repeat (2) @(negedge wb_clk);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_write();
    test_burst();
    test_reset_mid_burst();
    test_watchdog();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
